// File: rtl/mux_iw_driver_if.sv
// Project-array bus: packed input word and one-hot enable out to the projects,
// and the selected project's output word coming back.
interface mux_iw_driver_if #(
  parameter int NUM_PROJ = 16
);
  logic [17:0]         iw;
  logic [NUM_PROJ-1:0] ena;
  logic [23:0]         ow;

  modport master (output iw, output ena, input ow);
  modport slave  (input iw, input ena, output ow);
endinterface

// File: rtl/mux_iw_driver.sv
// Harness-side driver for the muxed project array: project selection with a
// drain/reset-hold switch sequence, divided project clock, input launch, output capture.
module mux_iw_driver #(
  parameter int NUM_PROJ   = 16,
  parameter int ADDR_W     = 4,
  parameter int CLKDIV_W   = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   sel_addr,
  input  logic                sel_valid,
  output logic                sel_ready,
  output logic [ADDR_W-1:0]   active_addr,
  input  logic [CLKDIV_W-1:0] clkdiv,
  input  logic                run,
  input  logic [7:0]          ui_in,
  input  logic [7:0]          uio_in,
  mux_iw_driver_if.master     proj,
  output logic [7:0]          uo_out,
  output logic [7:0]          uio_out,
  output logic [7:0]          uio_oe,
  output logic                cap_valid
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, RESET_HOLD, RUN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W-1:0]   active_addr_reg, active_addr_next;
  logic [NUM_PROJ-1:0] ena_reg, ena_next, ena_dec;
  logic                pclk_reg, pclk_next;
  logic                prst_reg, prst_next;
  logic [15:0]         data_reg, data_next;
  logic [CLKDIV_W-1:0] cnt_reg, cnt_next;
  logic                drain_cnt_reg, drain_cnt_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [23:0]         cap_reg, cap_next;
  logic                cap_valid_reg, cap_valid_next;

  logic accept, div_en, tc, fall_tog, hold_done, addr_ok, capture;

  assign sel_ready = (state_reg == IDLE) || (state_reg == RUN);
  assign accept    = sel_valid && sel_ready;
  assign div_en    = (state_reg == RESET_HOLD) || ((state_reg == RUN) && run);
  assign tc        = div_en && (cnt_reg == clkdiv);
  assign fall_tog  = tc && pclk_reg;
  assign hold_done = (state_reg == RESET_HOLD) && fall_tog &&
                     (hold_cnt_reg == HOLD_W'(RST_CYCLES - 1));
  assign addr_ok   = 32'(addr_reg) < 32'(NUM_PROJ);
  // Sample ow on the last low-phase cycle, unless a switch is being accepted.
  assign capture   = (state_reg == RUN) && tc && !pclk_reg && !accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PROJ; gi++) begin : g_ena_dec
      assign ena_dec[gi] = (addr_reg == ADDR_W'(gi));
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (accept) state_next = DRAIN;
      DRAIN:      if (drain_cnt_reg) state_next = addr_ok ? RESET_HOLD : IDLE;
      RESET_HOLD: if (hold_done) state_next = RUN;
      RUN:        if (accept) state_next = DRAIN;
      default:    state_next = IDLE;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    addr_next        = addr_reg;
    active_addr_next = active_addr_reg;
    ena_next         = ena_reg;
    pclk_next        = pclk_reg;
    prst_next        = prst_reg;
    data_next        = data_reg;
    cnt_next         = cnt_reg;
    hold_cnt_next    = hold_cnt_reg;
    cap_next         = cap_reg;
    cap_valid_next   = 1'b0;
    drain_cnt_next   = (state_reg == DRAIN) && !drain_cnt_reg;

    if (div_en) begin
      if (tc) begin
        cnt_next  = '0;
        pclk_next = ~pclk_reg;
      end else begin
        cnt_next  = cnt_reg + 1'b1;
      end
    end
    // New inputs go out on the falling toggle: half a period of setup.
    if (fall_tog) data_next = {uio_in, ui_in};
    if ((state_reg == RESET_HOLD) && fall_tog) hold_cnt_next = hold_cnt_reg + 1'b1;
    if (hold_done) prst_next = 1'b1;

    if ((state_reg == DRAIN) && drain_cnt_reg && addr_ok) begin
      ena_next         = ena_dec;
      active_addr_next = addr_reg;
    end

    if (capture) begin
      cap_next       = proj.ow;
      cap_valid_next = 1'b1;
    end

    if (accept) begin
      addr_next      = sel_addr;
      ena_next       = '0;
      pclk_next      = 1'b0;
      prst_next      = 1'b0;
      cnt_next       = '0;
      hold_cnt_next  = '0;
      drain_cnt_next = 1'b0;
      data_next      = data_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg        <= '0;
      active_addr_reg <= '0;
      ena_reg         <= '0;
      pclk_reg        <= 1'b0;
      prst_reg        <= 1'b0;
      data_reg        <= '0;
      cnt_reg         <= '0;
      drain_cnt_reg   <= 1'b0;
      hold_cnt_reg    <= '0;
      cap_reg         <= '0;
      cap_valid_reg   <= 1'b0;
    end else begin
      addr_reg        <= addr_next;
      active_addr_reg <= active_addr_next;
      ena_reg         <= ena_next;
      pclk_reg        <= pclk_next;
      prst_reg        <= prst_next;
      data_reg        <= data_next;
      cnt_reg         <= cnt_next;
      drain_cnt_reg   <= drain_cnt_next;
      hold_cnt_reg    <= hold_cnt_next;
      cap_reg         <= cap_next;
      cap_valid_reg   <= cap_valid_next;
    end
  end

  assign proj.iw     = {data_reg, prst_reg, pclk_reg};
  assign proj.ena    = ena_reg;
  assign active_addr = active_addr_reg;
  assign uo_out      = cap_reg[7:0];
  assign uio_out     = cap_reg[15:8];
  assign uio_oe      = cap_reg[23:16];
  assign cap_valid   = cap_valid_reg;

endmodule

// File: doc/mux_iw_driver.md
Name: mux_iw_driver

Overview:
Harness-side driver for the muxed project array. It owns the per-project `iw`/`ow` bus.
- Selects one project at a time via a one-hot `ena`.
- Sequences a clean project switch with a reset hold.
- Generates the divided project clock and the project reset.
- Launches `ui_in`/`uio_in` onto `iw`.
- Captures the selected project's `ow` just before each project-clock rising edge.

Parameters:
- NUM_PROJ, 16, number of projects on the mux (`ena` width).
- ADDR_W, 4, project address width.
- CLKDIV_W, 8, width of the clock-divider setting.
- RST_CYCLES, 4, project-clock periods that project rst_n is held low after a switch.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sel_addr  in  ADDR_W  requested project address
- sel_valid  in  1  switch request
- sel_ready  out  1  switch request may be accepted
- active_addr  out  ADDR_W  currently enabled project address
- clkdiv  in  CLKDIV_W  project clock half-period = clkdiv+1 system cycles
- run  in  1  enables project-clock toggling while in RUN
- ui_in  in  8  project input bus
- uio_in  in  8  project bidir input bus
- iw  out  18  project input word: [0]=pclk, [1]=project rst_n, [9:2]=ui_in, [17:10]=uio_in
- ena  out  NUM_PROJ  one-hot project enable
- ow  in  24  selected project output word: [7:0]=uo_out, [15:8]=uio_out, [23:16]=uio_oe
- uo_out  out  8  captured ow[7:0]
- uio_out  out  8  captured ow[15:8]
- uio_oe  out  8  captured ow[23:16]
- cap_valid  out  1  one-cycle pulse when uo_out/uio_out/uio_oe updated

Behaviour:
- Reset (async assert, sync-to-clk release):
  - iw=0, ena=0, active_addr=0, uo_out/uio_out/uio_oe=0, cap_valid=0.
  - sel_ready=1, state IDLE, divider count=0.
- States:
  - IDLE → DRAIN: on sel_valid & sel_ready.
  - DRAIN → RESET_HOLD: after 2 cycles.
  - RESET_HOLD → RUN: after RST_CYCLES project-clock periods.
  - RUN → DRAIN: on a new accepted request.
- sel_ready: 1 only in IDLE and RUN; 0 in DRAIN and RESET_HOLD.
- Accept (sel_valid & sel_ready, cycle T):
  - Latch sel_addr.
  - T+1: ena=0, iw[0]=0, iw[1]=0, divider count cleared; state DRAIN.
- Out-of-range address (sel_addr ≥ NUM_PROJ):
  - DRAIN exits to IDLE instead of RESET_HOLD.
  - ena stays 0, active_addr unchanged.
- DRAIN exit into RESET_HOLD:
  - ena = 1<<latched addr; active_addr = latched addr.
  - iw[1]=0 for the whole of RESET_HOLD.
  - The divider runs regardless of run, so synchronous-reset projects see RST_CYCLES rising edges.
- RESET_HOLD exit:
  - Occurs on the cycle of the RST_CYCLES-th falling-edge toggle.
  - iw[1]=1, state RUN, sel_ready=1.
- Divider (RESET_HOLD, or RUN with run=1):
  - Count increments each cycle.
  - At count==clkdiv: pclk (iw[0]) toggles and count reloads to 0.
  - clkdiv=0 gives pclk = clk/2.
  - A clkdiv change mid-count applies from the next comparison. If count > new clkdiv, the count wraps to 0 at its max value; this is legal and not an error.
- run=0 in RUN: count and pclk freeze at their current values; no captures occur.
- Input launch: on every toggle to pclk=0, iw[17:2] ← {uio_in, ui_in}. This gives half a period of setup before the next rising edge. Outside these toggles iw[17:2] holds.
- Capture:
  - In RUN only, on a terminal-count cycle with pclk==0 (the cycle before pclk rises), register ow into uo_out/uio_out/uio_oe and pulse cap_valid next cycle.
  - No capture in RESET_HOLD/DRAIN/IDLE; captured outputs hold their last value.
- Simultaneous events:
  - If a request is accepted on a would-be capture cycle, the capture is suppressed.
  - sel_valid while sel_ready=0 is ignored (not queued).
- Async reset mid-switch: everything returns to reset values immediately, including ena=0.

Test Plan:
- Reset then request addr 3, clkdiv=1, run=1:
  - ena=0x0008 after 2 DRAIN cycles.
  - iw[1]=0 for 4 pclk periods (16 clk), then 1.
  - sel_ready=0 throughout the switch, then back to 1.
- In RUN, clkdiv=0, ow=0xA5_3C_F0 held:
  - pclk toggles every clk.
  - uo_out=0xF0, uio_out=0x3C, uio_oe=0xA5.
  - One cap_valid per pclk period, asserted the cycle after each pre-rise cycle.
- Drive ui_in=0x5A, uio_in=0xC3 mid high phase: iw[9:2]=0x5A, iw[17:10]=0xC3 appear only at the next falling toggle.
- Request addr 7 while RUN on addr 3:
  - ena goes 0 for exactly 2 cycles, then 0x0080.
  - No cap_valid until RUN is re-entered.
- Request addr 15 with NUM_PROJ=8: ena stays 0, active_addr unchanged, sel_ready=1 after DRAIN, state IDLE.
- Assert rst_n low during RESET_HOLD: iw, ena, and outputs go to 0 asynchronously, sel_ready=1 after release.
